// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fft_pkg;

  localparam int FFT_POINTS = 16;
  localparam int CPLX_W     = 36;
  localparam int HALF_W     = 18;
  localparam int IDX_W      = 4;
  localparam int COEF_W     = 17;

  // One FFT input word: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    BUSY_PEND = 2'd2
  } fb_state_t;

  // Q1.16 Hann coefficients: round(65536 * 0.5 * (1 - cos(2*pi*n/16))).
  localparam logic [COEF_W-1:0] HANN_COEF [FFT_POINTS] = '{
    17'd0,     17'd2494,  17'd9598,  17'd20228,
    17'd32768, 17'd45308, 17'd55938, 17'd63042,
    17'd65536, 17'd63042, 17'd55938, 17'd45308,
    17'd32768, 17'd20228, 17'd9598,  17'd2494
  };

  // Real audio samples enter the FFT with a zero imaginary part.
  function automatic cplx_t real_to_cplx(input logic signed [HALF_W-1:0] re);
    cplx_t c;
    c.re = re;
    c.im = '0;
    return c;
  endfunction

endpackage

// File: rtl/fft_hann_window.sv
// Hann window stage: coefficient lookup, multiply, round half-up, saturate.
// Latency: 1 cycle (single output register); bank/index tag travels alongside.
// Backpressure: none; every valid input appears one cycle later.
module fft_hann_window
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_vld,
  input  logic signed [HALF_W-1:0] i_sample,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic                     i_bank,
  output logic                     o_vld,
  output logic signed [HALF_W-1:0] o_sample,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_bank
);

  localparam logic signed [35:0] RND     = 36'sd32768;
  localparam logic signed [35:0] SAT_MAX = 36'sd131071;
  localparam logic signed [35:0] SAT_MIN = -36'sd131072;

  logic signed [35:0]       w_coef;
  logic signed [35:0]       w_prod;
  logic signed [35:0]       w_shift;
  logic signed [HALF_W-1:0] w_sat;

  // Windowed sample: coefficient is unsigned so it is zero-extended before the signed multiply.
  always_comb begin
    w_coef  = 36'($signed({1'b0, HANN_COEF[i_idx]}));
    w_prod  = 36'(i_sample) * w_coef;
    w_shift = (w_prod + RND) >>> 16;
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[HALF_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[HALF_W-1:0];
    end else begin
      w_sat = w_shift[HALF_W-1:0];
    end
  end

  // Pipeline register carrying the windowed value and its destination slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_vld    <= 1'b0;
      o_sample <= '0;
      o_idx    <= '0;
      o_bank   <= 1'b0;
    end else begin
      o_vld    <= i_vld;
      o_sample <= w_sat;
      o_idx    <= i_idx;
      o_bank   <= i_bank;
    end
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding fft_16point; optional Hann window via HANN_WINDOW_EN.
// Latency: last sample to fft_start is 1 cycle (2 cycles with HANN_WINDOW_EN).
// Backpressure: none upstream; samples arriving while both banks are full are dropped and flag overrun.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int SAMPLE_W = 18,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                fft_done,
  input  logic                clr_overrun,
  output logic                fft_start,
  output logic [CPLX_W-1:0]   out0,
  output logic [CPLX_W-1:0]   out1,
  output logic [CPLX_W-1:0]   out2,
  output logic [CPLX_W-1:0]   out3,
  output logic [CPLX_W-1:0]   out4,
  output logic [CPLX_W-1:0]   out5,
  output logic [CPLX_W-1:0]   out6,
  output logic [CPLX_W-1:0]   out7,
  output logic [CPLX_W-1:0]   out8,
  output logic [CPLX_W-1:0]   out9,
  output logic [CPLX_W-1:0]   out10,
  output logic [CPLX_W-1:0]   out11,
  output logic [CPLX_W-1:0]   out12,
  output logic [CPLX_W-1:0]   out13,
  output logic [CPLX_W-1:0]   out14,
  output logic [CPLX_W-1:0]   out15,
  output logic                overrun,
  output logic [CNT_W-1:0]    frame_count
);

  fb_state_t                r_state;
  fb_state_t                w_state_nxt;
  logic                     r_wr_bank;
  logic                     r_rd_bank;
  logic [IDX_W-1:0]         r_wr_idx;
  logic [CNT_W-1:0]         r_frame_count;
  logic                     r_overrun;
  logic                     r_start;
  cplx_t                    r_bank [2][FFT_POINTS];

  logic                     w_acc;
  logic                     w_drop;
  logic                     w_swap;
  logic                     w_complete;
  logic signed [HALF_W-1:0] w_sample_sx;

  logic                     w_wr_en;
  logic                     w_wr_bank;
  logic [IDX_W-1:0]         w_wr_idx;
  logic signed [HALF_W-1:0] w_wr_re;

  assign w_sample_sx = HALF_W'(signed'(sample_in));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: in BUSY a simultaneous done is retired before the completed frame is considered.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_complete) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_complete && !fft_done) begin
          w_state_nxt = BUSY_PEND;
        end else if (fft_done && !w_complete) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_PEND: begin
        if (fft_done) w_state_nxt = BUSY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept/drop the incoming sample and decide when banks swap.
  always_comb begin
    w_acc      = 1'b0;
    w_drop     = 1'b0;
    w_swap     = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        w_acc      = sample_valid;
        w_complete = sample_valid && (r_wr_idx == IDX_W'(FFT_POINTS - 1));
        w_swap     = w_complete;
      end
      BUSY: begin
        w_acc      = sample_valid;
        w_complete = sample_valid && (r_wr_idx == IDX_W'(FFT_POINTS - 1));
        w_swap     = w_complete && fft_done;
      end
      BUSY_PEND: begin
        w_drop = sample_valid;
        w_swap = fft_done;
      end
      default: begin
        w_acc = 1'b0;
      end
    endcase
  end

  // Write pointer, bank selection and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_wr_idx      <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_acc) r_wr_idx <= r_wr_idx + IDX_W'(1);
      if (w_swap) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= ~r_wr_bank;
        r_wr_idx      <= '0;
        r_frame_count <= r_frame_count + CNT_W'(1);
      end
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef HANN_WINDOW_EN
  logic r_start_d;

  // The bank swap is decided as the sample enters the window, so start waits for its write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_d <= 1'b0;
      r_start   <= 1'b0;
    end else begin
      r_start_d <= w_swap;
      r_start   <= r_start_d;
    end
  end

  fft_hann_window u_hann_window (
    .clk      (clk),
    .reset    (reset),
    .i_vld    (w_acc),
    .i_sample (w_sample_sx),
    .i_idx    (r_wr_idx),
    .i_bank   (r_wr_bank),
    .o_vld    (w_wr_en),
    .o_sample (w_wr_re),
    .o_idx    (w_wr_idx),
    .o_bank   (w_wr_bank)
  );
`else
  // Start pulse follows the swap by one cycle, when the last sample is already stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= 1'b0;
    end else begin
      r_start <= w_swap;
    end
  end

  assign w_wr_en   = w_acc;
  assign w_wr_re   = w_sample_sx;
  assign w_wr_idx  = r_wr_idx;
  assign w_wr_bank = r_wr_bank;
`endif

  // Bank storage; reset clears both banks so the presented frame reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FFT_POINTS; k++) begin
          r_bank[b][k] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_bank[w_wr_bank][w_wr_idx] <= real_to_cplx(w_wr_re);
    end
  end

  assign fft_start   = r_start;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

  assign out0  = r_bank[r_rd_bank][0];
  assign out1  = r_bank[r_rd_bank][1];
  assign out2  = r_bank[r_rd_bank][2];
  assign out3  = r_bank[r_rd_bank][3];
  assign out4  = r_bank[r_rd_bank][4];
  assign out5  = r_bank[r_rd_bank][5];
  assign out6  = r_bank[r_rd_bank][6];
  assign out7  = r_bank[r_rd_bank][7];
  assign out8  = r_bank[r_rd_bank][8];
  assign out9  = r_bank[r_rd_bank][9];
  assign out10 = r_bank[r_rd_bank][10];
  assign out11 = r_bank[r_rd_bank][11];
  assign out12 = r_bank[r_rd_bank][12];
  assign out13 = r_bank[r_rd_bank][13];
  assign out14 = r_bank[r_rd_bank][14];
  assign out15 = r_bank[r_rd_bank][15];

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
Upstream feeder for fft_16point. Collects a stream of real audio samples into 16-point frames using a ping-pong buffer. Presents each complete frame as sixteen 36-bit complex words on in0..in15 of the FFT and issues a start pulse. Holds the frame stable until the FFT reports done, while the other bank keeps filling.

Parameters:
SAMPLE_W, 18, width of the incoming signed sample; legal range 8..18; sign-extended to 18 bits.
CNT_W, 8, width of the frame counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_in  input  SAMPLE_W  signed audio sample
sample_valid  input  1  sample_in is valid this cycle
fft_done  input  1  FFT finished the current frame (level; first high cycle while busy counts)
clr_overrun  input  1  clears the overrun flag
fft_start  output  1  single-cycle pulse: out0..out15 hold a new frame
out0..out15  output  36 each  frame word k = {real[35:18], imag[17:0]}; real = sign-extended sample k, imag = 0
overrun  output  1  sticky flag: a sample was dropped
frame_count  output  CNT_W  number of frames issued; wraps

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Storage is two banks of 16 x 36 bits. wr_bank/wr_idx select the write slot; rd_bank drives out0..out15.
- Reset values:
  - state = IDLE, wr_bank = 0, rd_bank = 1, wr_idx = 0.
  - All bank words = 0, so out0..out15 = 0.
  - fft_start = 0, overrun = 0, frame_count = 0.
  - Reset mid-frame or mid-FFT discards everything.
- Sample acceptance: in IDLE or BUSY, a cycle with sample_valid writes bank[wr_bank][wr_idx] and increments wr_idx (mod 16).
- Frame complete: a sample accepted with wr_idx = 15.
- State IDLE (no frame in FFT). On frame complete:
  - rd_bank <= wr_bank; wr_bank toggles; wr_idx <= 0.
  - fft_start = 1 the next cycle; frame_count++; go to BUSY.
- State BUSY (FFT working on rd_bank):
  - fft_done = 1 with no frame complete -> IDLE.
  - Frame complete with fft_done = 0 -> BUSY_PEND.
  - Frame complete and fft_done = 1 in the same cycle: done is processed first. Swap, fft_start next cycle, stay in BUSY.
- State BUSY_PEND (write bank full, FFT still busy):
  - sample_valid -> sample is dropped and overrun <= 1.
  - fft_done = 1 -> swap, wr_idx <= 0, fft_start next cycle, go to BUSY. A sample arriving in that same cycle is dropped and sets overrun.
- Latency: from the 16th sample's cycle to the fft_start cycle is 1 cycle. out0..out15 are valid in the fft_start cycle and stay stable until the cycle after fft_done.
- fft_start is never high for two consecutive cycles.
- overrun:
  - clr_overrun clears it.
  - If a drop and clr_overrun happen in the same cycle, set wins.
- frame_count wraps from 2^CNT_W-1 to 0.
- fft_done while in IDLE is ignored.

Optional Feature:
- Macro: HANN_WINDOW_EN.
- Defined:
  - Each sample is multiplied by a 17-bit unsigned Q1.16 Hann coefficient w[wr_idx] = round(65536 * 0.5 * (1 - cos(2*pi*n/16))). So w[0] = 0 and w[8] = 65536.
  - The product is rounded half-up, shifted right by 16 and saturated to 18 bits before storage.
  - This adds one pipeline register, so the 16th-sample-to-fft_start latency becomes 2 cycles.
  - Overrun and drop decisions use the state at the cycle the sample enters the window stage.
- Undefined: samples are stored unmodified; latency is 1 cycle.

Decomposition:
- Package fft_pkg:
  - FFT_POINTS = 16, CPLX_W = 36, HALF_W = 18.
  - typedef cplx_t: packed struct {signed re[17:0], signed im[17:0]}.
  - Enum fb_state_t {IDLE, BUSY, BUSY_PEND}.
  - Constant HANN_COEF[16] (17-bit).
- Sub-module: fft_hann_window. It holds the coefficient lookup, multiply, round, saturate and the single pipeline register, and is instantiated only under HANN_WINDOW_EN.

Test Plan:
1. Ramp 0..15, one sample per cycle, fft_done held 0 -> fft_start pulses exactly once, 1 cycle after sample 15. Expected outputs: out3 = 36'h0000C0000, out15 = 36'h0003C0000, frame_count = 1.
2. Sample 18'h3FFFF (-1) as sample 0 -> out0 = 36'hFFFFC0000; imag field = 0.
3. Two frames back-to-back with fft_done low, then 3 more samples -> state BUSY_PEND, the 3 samples are dropped, overrun = 1. Pulse fft_done -> fft_start next cycle, out0..out15 show frame 2, frame_count = 2.
4. In BUSY, assert fft_done in the same cycle as the 16th sample of frame 2 -> fft_start next cycle, frame 2 is presented, overrun stays 0.
5. Reset after 7 samples of a frame, then feed 16 new samples -> the frame contains only the new 16 samples, frame_count = 1. clr_overrun clears overrun.
6. HANN_WINDOW_EN with constant input 1000 -> out0 real = 0, out8 real = 1000, out4 real = 500. fft_start arrives 2 cycles after the last sample.
